// File: rtl/cpu_muldiv_defs.sv
// cpu_muldiv_defs: shared definitions for the RV32M multiply/divide unit.
//   - RV32M funct3 operation codes
//   - FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   - finalize(): sign correction and result-half selection
package cpu_muldiv_defs;

    localparam logic [2:0] OpMul    = 3'd0;
    localparam logic [2:0] OpMulh   = 3'd1;
    localparam logic [2:0] OpMulhsu = 3'd2;
    localparam logic [2:0] OpMulhu  = 3'd3;
    localparam logic [2:0] OpDiv    = 3'd4;
    localparam logic [2:0] OpDivu   = 3'd5;
    localparam logic [2:0] OpRem    = 3'd6;
    localparam logic [2:0] OpRemu   = 3'd7;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // raw holds the 64-bit magnitude product, or the quotient in raw[31:0] (upper half zero).
    // The whole 64-bit value is negated so the high product half gets the borrow right.
    function automatic logic [31:0] finalize(input logic [2:0]  op,
                                             input logic [63:0] raw,
                                             input logic [31:0] rem,
                                             input logic        neg_res,
                                             input logic        neg_rem);
        logic [63:0] p;
        logic [31:0] r;
        p = neg_res ? (~raw + 64'd1) : raw;
        r = neg_rem ? (~rem + 32'd1) : rem;
        case (op)
            OpMul, OpDiv, OpDivu:     finalize = p[31:0];
            OpMulh, OpMulhsu, OpMulhu: finalize = p[63:32];
            default:                  finalize = r;
        endcase
    endfunction

endpackage

// File: rtl/cpu_muldiv_step.sv
// cpu_muldiv_step: one combinational iteration of the iterative datapath.
//   is_div  : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_in  : multiply {hi, multiplier}; divide [31:0] = dividend shifting into quotient
//   rem_in  : divide partial remainder (always < divisor)
//   opb     : multiplicand / divisor magnitude
//   acc_out, rem_out : state after this iteration
module cpu_muldiv_step (
    input  logic        is_div,
    input  logic [63:0] acc_in,
    input  logic [31:0] rem_in,
    input  logic [31:0] opb,
    output logic [63:0] acc_out,
    output logic [31:0] rem_out
);

    logic [32:0] sum;
    logic [32:0] rsh;
    logic        ge;

    always_comb begin
        sum     = {1'b0, acc_in[63:32]} + {1'b0, opb};
        // 33-bit shifted partial remainder
        rsh     = {rem_in, acc_in[31]};
        ge      = (rsh >= {1'b0, opb});
        acc_out = acc_in;
        rem_out = rem_in;
        if (is_div) begin
            // True difference is < divisor, so a 32-bit subtract is exact
            rem_out        = ge ? (rsh[31:0] - opb) : rsh[31:0];
            acc_out[31:0]  = {acc_in[30:0], ge};
        end else if (acc_in[0]) begin
            acc_out = {sum, acc_in[31:1]};
        end else begin
            acc_out = {1'b0, acc_in[63:1]};
        end
    end

endmodule

// File: rtl/cpu_muldiv_unit.sv
// cpu_muldiv_unit: iterative RV32M multiply/divide unit feeding the register file write port.
//   clk, rst (sync, active-high)
//   start/op/a/b/rd_in : request, sampled only when idle
//   busy               : accept edge through end of the done cycle
//   done/result/rd_out : one-cycle registered writeback; we = done && rd_out != 0
// Optional macro CPU_MULDIV_FAST_MUL_EN: single-cycle multiply using one 64-bit '*'.
module cpu_muldiv_unit
    import cpu_muldiv_defs::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            we
);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] opb_q, opb_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] rem_q, rem_d;
    logic        neg_q, neg_d;
    logic        neg_rem_q, neg_rem_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  rd_out_q, rd_out_d;
    logic        we_q, we_d;

    logic        a_signed, b_signed, a_neg, b_neg, is_special;
    logic [31:0] a_mag, b_mag, special_res;
    logic [63:0] step_acc;
    logic [31:0] step_rem;

    cpu_muldiv_step u_step (
        .is_div  (op_q[2]),
        .acc_in  (acc_q),
        .rem_in  (rem_q),
        .opb     (opb_q),
        .acc_out (step_acc),
        .rem_out (step_rem)
    );

    // Operand conditioning and special-case detection on the raw request
    always_comb begin
        a_signed    = (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
        b_signed    = (op == OpMulh) || (op == OpDiv) || (op == OpRem);
        a_neg       = a_signed & a[31];
        b_neg       = b_signed & b[31];
        a_mag       = a_neg ? (~a + 32'd1) : a;
        b_mag       = b_neg ? (~b + 32'd1) : b;
        is_special  = 1'b0;
        special_res = 32'h0;
        if (op[2] && (b == 32'h0)) begin
            is_special  = 1'b1;
            special_res = ((op == OpDiv) || (op == OpDivu)) ? 32'hFFFF_FFFF : a;
        end else if (((op == OpDiv) || (op == OpRem)) &&
                     (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
            is_special  = 1'b1;
            special_res = (op == OpDiv) ? 32'h8000_0000 : 32'h0;
        end
    end

`ifdef CPU_MULDIV_FAST_MUL_EN
    logic [63:0] fast_prod;
    assign fast_prod = {32'h0, a_mag} * {32'h0, b_mag};
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rd_d      = rd_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        we_d      = 1'b0;
        result_d  = result_q;
        rd_out_d  = rd_out_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    op_d      = op;
                    rd_d      = rd_in;
                    opb_d     = b_mag;
                    acc_d     = {32'h0, a_mag};
                    rem_d     = 32'h0;
                    neg_d     = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = 5'd0;
                    busy_d    = 1'b1;
                    state_d   = StRun;
                    if (is_special) begin
                        state_d  = StDone;
                        done_d   = 1'b1;
                        result_d = special_res;
                        rd_out_d = rd_in;
                        we_d     = (rd_in != 5'd0);
                    end
`ifdef CPU_MULDIV_FAST_MUL_EN
                    else if (!op[2]) begin
                        state_d  = StDone;
                        done_d   = 1'b1;
                        result_d = finalize(op, fast_prod, 32'h0, a_neg ^ b_neg, a_neg);
                        rd_out_d = rd_in;
                        we_d     = (rd_in != 5'd0);
                    end
`endif
                end
            end
            StRun: begin
                acc_d = step_acc;
                rem_d = step_rem;
                cnt_d = cnt_q + 5'd1;
                // Register the finished result on the edge that enters DONE
                if (cnt_q == 5'd31) begin
                    state_d  = StDone;
                    done_d   = 1'b1;
                    result_d = finalize(op_q, step_acc, step_rem, neg_q, neg_rem_q);
                    rd_out_d = rd_q;
                    we_d     = (rd_q != 5'd0);
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 5'd0;
            op_q      <= 3'd0;
            rd_q      <= 5'd0;
            opb_q     <= 32'h0;
            acc_q     <= 64'h0;
            rem_q     <= 32'h0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= 32'h0;
            rd_out_q  <= 5'd0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            rd_out_q  <= rd_out_d;
            we_q      <= we_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign rd_out = rd_out_q;
    assign we     = we_q;

endmodule
